// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S DAC arbiter: source modes, last-source codes, FSM states.
package i2s_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_MIX   = 2'b10,
        MODE_MUTE  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_A    = 2'b01,
        SRC_B    = 2'b10,
        SRC_MIX  = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_PRESENT = 2'b10
    } state_e;

endpackage

// File: rtl/i2s_dac_arbiter_sat_add.sv
// Signed two's-complement adder that clamps to the representable range instead of wrapping.
module sat_add
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH:0] wide;

    assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

    // Overflow shows up as the two top bits of the sign-extended sum disagreeing.
    always_comb begin
        sum = wide[DATA_WIDTH-1:0];
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
            sum = wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/i2s_dac_arbiter.sv
// Two-source arbiter feeding the I2S DAC: fixed priority, round-robin, saturating mix or mute,
// with one-entry holds per source and zero-fill on sink starvation.
module i2s_dac_arbiter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            last_src,
    output logic [15:0]           underrun_cnt
);

    mode_e                 md;
    state_e                state;
    src_e                  sel;
    src_e                  pick;
    logic                  mute;
    logic                  rr_b;
    logic [DATA_WIDTH-1:0] hold_a;
    logic [DATA_WIDTH-1:0] hold_b;
    logic                  hold_a_full;
    logic                  hold_b_full;
    logic                  a_take;
    logic                  b_take;
    logic                  a_avail;
    logic                  b_avail;
    logic                  a_clr;
    logic                  b_clr;
    logic                  eligible;
    logic [DATA_WIDTH-1:0] mix_a;
    logic [DATA_WIDTH-1:0] mix_b;
    logic [DATA_WIDTH-1:0] mix_sum;

    assign md   = mode_e'(mode);
    assign mute = (md == MODE_MUTE);

    assign a_ready = mute || !hold_a_full;
    assign b_ready = mute || !hold_b_full;

    // Muted handshakes complete but the sample is dropped on the floor.
    assign a_take = a_valid && a_ready && !mute;
    assign b_take = b_valid && b_ready && !mute;

    // An arriving sample counts for the IDLE decision so accept-to-valid stays at 2 clk.
    assign a_avail = hold_a_full || a_take;
    assign b_avail = hold_b_full || b_take;

    always_comb begin
        pick = SRC_NONE;
        case (md)
            MODE_FIXED: begin
                if (a_avail)      pick = SRC_A;
                else if (b_avail) pick = SRC_B;
            end
            MODE_RR: begin
                if (a_avail && b_avail) pick = rr_b ? SRC_B : SRC_A;
                else if (a_avail)       pick = SRC_A;
                else if (b_avail)       pick = SRC_B;
            end
            MODE_MIX: begin
                if ((a_avail && b_avail) || (out_ready && (a_avail || b_avail)))
                    pick = SRC_MIX;
            end
            default: pick = SRC_NONE;
        endcase
    end

    assign eligible = (pick != SRC_NONE);

    assign a_clr = (state == ST_LOAD) && ((sel == SRC_A) || (sel == SRC_MIX));
    assign b_clr = (state == ST_LOAD) && ((sel == SRC_B) || (sel == SRC_MIX));

    // Hold flags are stable between IDLE and LOAD, so they tell which mix operands exist.
    assign mix_a = hold_a_full ? hold_a : '0;
    assign mix_b = hold_b_full ? hold_b : '0;

    sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
        .a   (mix_a),
        .b   (mix_b),
        .sum (mix_sum)
    );

    // A refill landing on the consuming cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_a      <= '0;
            hold_b      <= '0;
            hold_a_full <= 1'b0;
            hold_b_full <= 1'b0;
        end else begin
            if (a_take) begin
                hold_a      <= a_data;
                hold_a_full <= 1'b1;
            end else if (a_clr) begin
                hold_a_full <= 1'b0;
            end
            if (b_take) begin
                hold_b      <= b_data;
                hold_b_full <= 1'b1;
            end else if (b_clr) begin
                hold_b_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sel          <= SRC_NONE;
            rr_b         <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            last_src     <= SRC_NONE;
            underrun_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eligible || out_ready) begin
                        sel   <= pick;
                        state <= ST_LOAD;
                        if (!eligible && !mute && underrun_cnt != 16'hFFFF)
                            underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                ST_LOAD: begin
                    case (sel)
                        SRC_A: begin
                            out_data <= hold_a;
                            rr_b     <= 1'b1;
                        end
                        SRC_B: begin
                            out_data <= hold_b;
                            rr_b     <= 1'b0;
                        end
                        SRC_MIX: out_data <= mix_sum;
                        default: out_data <= '0;
                    endcase
                    out_valid <= 1'b1;
                    state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        last_src  <= sel;
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_dac_arbiter.sv
// Self-checking bench for i2s_dac_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_i2s_dac_arbiter;

    localparam logic [1:0] M_FIXED = 2'b00;
    localparam logic [1:0] M_RR    = 2'b01;
    localparam logic [1:0] M_MIX   = 2'b10;
    localparam logic [1:0] M_MUTE  = 2'b11;
    localparam logic [1:0] S_NONE  = 2'b00;
    localparam logic [1:0] S_A     = 2'b01;
    localparam logic [1:0] S_B     = 2'b10;
    localparam logic [1:0] S_MIX   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [15:0] a_data, b_data, out_data;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic        out_valid, out_ready;
    logic [1:0]  last_src;
    logic [15:0] underrun_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]  mode;
        logic        a_en;
        logic [15:0] a;
        logic        b_en;
        logic [15:0] b;
        int          n;
        logic [15:0] d0;
        logic [1:0]  s0;
        logic [15:0] d1;
        logic [1:0]  s1;
    } vec_t;
    vec_t vecs[8];

    i2s_dac_arbiter #(.DATA_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .a_data       (a_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_data       (b_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .last_src     (last_src),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each transfer's data, then last_src on the following negedge.
    logic       src_pending = 1'b0;
    logic [1:0] src_exp;
    always @(negedge clk) begin
        if (src_pending) begin
            chk("last_src", {30'd0, last_src}, {30'd0, src_exp});
            src_pending = 1'b0;
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                src_exp     = e.s;
                src_pending = 1'b1;
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic [1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = M_FIXED;
        a_data    = '0;
        b_data    = '0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{M_FIXED, 1'b1, 16'h1234, 1'b1, 16'h0F00, 2, 16'h1234, S_A,   16'h0F00, S_B};
        vecs[1] = '{M_RR,    1'b1, 16'h1111, 1'b1, 16'h2222, 2, 16'h1111, S_A,   16'h2222, S_B};
        vecs[2] = '{M_MIX,   1'b1, 16'h7000, 1'b1, 16'h2000, 1, 16'h7FFF, S_MIX, 16'h0,    S_NONE};
        vecs[3] = '{M_MIX,   1'b1, 16'h8000, 1'b1, 16'hFFFF, 1, 16'h8000, S_MIX, 16'h0,    S_NONE};
        vecs[4] = '{M_MIX,   1'b1, 16'h0100, 1'b0, 16'h0,    1, 16'h0100, S_MIX, 16'h0,    S_NONE};
        vecs[5] = '{M_FIXED, 1'b0, 16'h0,    1'b1, 16'hBEEF, 1, 16'hBEEF, S_B,   16'h0,    S_NONE};
        vecs[6] = '{M_MUTE,  1'b1, 16'h1234, 1'b1, 16'h5678, 1, 16'h0000, S_NONE,16'h0,    S_NONE};
        vecs[7] = '{M_MIX,   1'b1, 16'h0123, 1'b1, 16'hFFFF, 1, 16'h0122, S_MIX, 16'h0,    S_NONE};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {16'd0, out_data}, 0);
        chk("rst_last_src", {30'd0, last_src}, 0);
        chk("rst_underrun", {16'd0, underrun_cnt}, 0);
        chk("rst_a_ready", {31'd0, a_ready}, 1);
        chk("rst_b_ready", {31'd0, b_ready}, 1);

        // Table: load holds with the sink stalled, then release the sink
        for (int v = 0; v < 8; v++) begin
            do_reset();
            mode    = vecs[v].mode;
            a_valid = vecs[v].a_en;
            a_data  = vecs[v].a;
            b_valid = vecs[v].b_en;
            b_data  = vecs[v].b;
            @(posedge clk);
            #1;
            a_valid = 1'b0;
            b_valid = 1'b0;
            push(vecs[v].d0, vecs[v].s0);
            if (vecs[v].n > 1) push(vecs[v].d1, vecs[v].s1);
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
            drain(50);
            out_ready = 1'b0;
            chk("vec_underrun", {16'd0, underrun_cnt}, 0);
        end

        // Round-robin streaming, sink always ready
        do_reset();
        mode = M_RR;
        for (int i = 0; i < 4; i++) begin
            push(16'hA000 + 16'(i), S_A);
            push(16'hB000 + 16'(i), S_B);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    a_data  = 16'hA000 + 16'(i);
                    a_valid = 1'b1;
                    c = 0;
                    @(negedge clk);
                    while (!a_ready && c < 50) begin
                        @(negedge clk);
                        c++;
                    end
                    if (c >= 50) chk("rr_a_ready_timeout", c, 0);
                    @(posedge clk);
                    #1;
                end
                a_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    b_data  = 16'hB000 + 16'(i);
                    b_valid = 1'b1;
                    c = 0;
                    @(negedge clk);
                    while (!b_ready && c < 50) begin
                        @(negedge clk);
                        c++;
                    end
                    if (c >= 50) chk("rr_b_ready_timeout", c, 0);
                    @(posedge clk);
                    #1;
                end
                b_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                drain(300);
                out_ready = 1'b0;
            end
        join
        chk("rr_underrun", {16'd0, underrun_cnt}, 0);

        // Starvation counts zeros; muted zeros do not
        do_reset();
        mode = M_FIXED;
        repeat (3) push(16'h0000, S_NONE);
        out_ready = 1'b1;
        drain(60);
        out_ready = 1'b0;
        chk("starve_underrun", {16'd0, underrun_cnt}, 3);
        mode = M_MUTE;
        repeat (3) push(16'h0000, S_NONE);
        out_ready = 1'b1;
        drain(60);
        out_ready = 1'b0;
        chk("mute_underrun", {16'd0, underrun_cnt}, 3);

        // Backpressure with a mode change mid-PRESENT, then reset drops the sample
        do_reset();
        mode    = M_FIXED;
        a_data  = 16'h5A5A;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        begin
            int c;
            c = 0;
            @(negedge clk);
            while (!out_valid && c < 10) begin
                @(negedge clk);
                c++;
            end
            chk("bp_out_valid", {31'd0, out_valid}, 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) mode = M_MUTE;
            @(negedge clk);
            chk("bp_stable", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h5A5A});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mode  = M_FIXED;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_out_data", {16'd0, out_data}, 0);
        chk("midrst_last_src", {30'd0, last_src}, 0);
        chk("midrst_underrun", {16'd0, underrun_cnt}, 0);
        chk("midrst_readies", {30'd0, a_ready, b_ready}, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(16'h0000, S_NONE);
        out_ready = 1'b1;
        drain(30);
        out_ready = 1'b0;
        chk("post_rst_underrun", {16'd0, underrun_cnt}, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
